// File: rtl/demux_1x4.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1x4
//  Purpose  : Registered 1-to-4 demultiplexer with valid/ready handshakes.
//             One producer stream is steered by in_sel into one of four
//             single-entry output holding registers. A stalled consumer
//             blocks only its own channel.
//  Ports    : clk, rst_n (async active-low)
//             in_data/in_sel/in_valid -> in_ready   producer side
//             outN_data/outN_valid    <- outN_ready consumer side, N = 1..4
//             cnt1..cnt4, cnt_clr     only with DEMUX_1X4_STATS_EN defined
//  Options  : `define DEMUX_1X4_STATS_EN adds per-channel pop counters
//  Revision : 1.0  initial release
// ============================================================================
module demux_1x4 #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out1_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [WIDTH-1:0]     out2_data,
  output logic                 out2_valid,
  input  logic                 out2_ready,
  output logic [WIDTH-1:0]     out3_data,
  output logic                 out3_valid,
  input  logic                 out3_ready,
  output logic [WIDTH-1:0]     out4_data,
  output logic                 out4_valid,
  input  logic                 out4_ready
`ifdef DEMUX_1X4_STATS_EN
  ,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3,
  output logic [CNT_WIDTH-1:0] cnt4
`endif
);

  logic [3:0]       vld;
  logic [3:0]       rdy;
  logic [3:0]       pop;
  logic [3:0]       acc;
  logic             accept;
  logic [WIDTH-1:0] ch_data [4];

  assign rdy = {out4_ready, out3_ready, out2_ready, out1_ready};

  // Only the addressed channel matters: it can take a word when empty, or
  // when its current word leaves on this same edge.
  assign in_ready = rst_n & (~vld[in_sel] | rdy[in_sel]);
  assign accept   = in_valid & in_ready;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_ch
      logic             full;
      logic [WIDTH-1:0] held;

      assign acc[i]     = accept & (in_sel == 2'(i));
      assign pop[i]     = full & rdy[i];
      assign vld[i]     = full;
      assign ch_data[i] = held;

      // An accept on the same edge as a pop keeps the channel full and
      // replaces the word, giving one word per cycle per channel.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          full <= 1'b0;
          held <= '0;
        end else if (acc[i]) begin
          full <= 1'b1;
          held <= in_data;
        end else if (pop[i]) begin
          full <= 1'b0;
        end
      end
    end
  endgenerate

  assign out1_data  = ch_data[0];
  assign out2_data  = ch_data[1];
  assign out3_data  = ch_data[2];
  assign out4_data  = ch_data[3];
  assign out1_valid = vld[0];
  assign out2_valid = vld[1];
  assign out3_valid = vld[2];
  assign out4_valid = vld[3];

`ifdef DEMUX_1X4_STATS_EN
  logic [CNT_WIDTH-1:0] cnt [4];

  generate
    for (genvar i = 0; i < 4; i++) begin : g_cnt
      // Clear has priority over a coincident pop; the count wraps naturally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt[i] <= '0;
        end else if (cnt_clr) begin
          cnt[i] <= '0;
        end else if (pop[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt1 = cnt[0];
  assign cnt2 = cnt[1];
  assign cnt3 = cnt[2];
  assign cnt4 = cnt[3];
`endif

endmodule
`default_nettype wire

// File: doc/demux_1x4.md
Name: demux_1x4

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshakes on every side; the write-direction counterpart of the 4-to-1 read mux.
- Routes a single producer stream, such as CPU store data, to one of four consumers (RAM, output ports, peripherals) according to `sel`.
- Each output channel has a one-entry holding register, so a stalled consumer blocks only its own channel.

Parameters:
WIDTH  32  data width of input and every output channel
CNT_WIDTH  16  width of per-channel transfer counters (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  producer data
in_sel  in  2  destination channel: 0→out1, 1→out2, 2→out3, 3→out4
in_valid  in  1  producer has a word
in_ready  out  1  block accepts the word this cycle
out1_data..out4_data  out  WIDTH each  channel holding-register contents
out1_valid..out4_valid  out  1 each  channel holds an undelivered word
out1_ready..out4_ready  in  1 each  consumer takes the word this cycle

Behaviour:
- Reset: the clock is single; reset is asynchronous and active-low (`rst_n`).
  - All `outN_valid` = 0 and all `outN_data` = 0 immediately on `rst_n` low, independent of `clk`.
  - `in_ready` = 0 while `rst_n` is low.
  - In-flight words are discarded; there is no replay after reset.
- Per-channel state (bit `vld[N]`):
  - EMPTY (`vld` = 0) or FULL (`vld` = 1).
  - `outN_valid` = `vld[N]`; `outN_data` = `reg[N]`.
- `in_ready`: combinational; `in_ready` = `rst_n` & (!`vld[in_sel]` | `out[in_sel]_ready`).
  - Depends only on the selected channel; other channels' state is ignored.
- Accept: `in_valid` & `in_ready` at a rising edge → `reg[in_sel]` <= `in_data`, `vld[in_sel]` <= 1.
  - Word visible on `outN` the next cycle: latency 1 cycle.
- Pop: `outN_valid` & `outN_ready` at an edge → `vld[N]` <= 0, unless the same edge accepts a new word for N.
- Simultaneous pop and accept on the same channel: `vld` stays 1 and `reg` is replaced.
  - Full throughput of 1 word/cycle per channel is sustained.
- Simultaneous pops on several channels are independent; all may complete in the same cycle.
- Stability rule: while `outN_valid` = 1 and `outN_ready` = 0, `outN_data` must not change.
- Producer side:
  - `in_valid` with `in_ready` = 0 means no state change; the producer holds its word.
  - `in_sel` may change while `in_valid` is held; the block evaluates the current `in_sel` each cycle.
- `outN_ready` asserted while EMPTY has no effect.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Data width: words pass through unmodified; no width conversion.

Optional Feature:
- Macro `DEMUX_1X4_STATS_EN`.
- Defined:
  - Adds output ports `cnt1..cnt4` (CNT_WIDTH each) and input `cnt_clr` (1).
  - `cntN` increments by 1 on every pop of channel N and wraps from all-ones to 0.
  - `cnt_clr` = 1 synchronously zeroes all counters; when clear and pop coincide, clear wins.
  - `rst_n` low zeroes all counters asynchronously.
- Not defined: the ports and logic are absent; the datapath behaviour is identical.

Test Plan:
- Reset: hold `rst_n` = 0 with `in_valid` = 1 → all `outN_valid` = 0, data = 0, `in_ready` = 0. Release reset → `in_ready` = 1.
- Single routing: `in_sel` = 2, `in_data` = 0xDEADBEEF, one-cycle valid → next cycle `out3_valid` = 1, `out3_data` = 0xDEADBEEF, other channels invalid; `out3_ready` pulse → `out3_valid` = 0.
- Backpressure: `out1_ready` = 0, two words 0x11 then 0x22 to `sel` 0.
  - 0x11 accepted; `in_ready` = 0 for 0x22 and `out1_data` stays 0x11.
  - Raise `out1_ready` → 0x22 accepted on the same edge 0x11 pops; `out1_data` = 0x22.
- Channel isolation: channel 0 FULL and stalled, then send 0x33 to `sel` 1 → accepted immediately and `out2_data` = 0x33 next cycle.
- Streaming: all `outN_ready` = 1, 256 random words with random `sel` every cycle → `in_ready` constantly 1, each word appears on its channel exactly once, one cycle later, in order.
- Async reset mid-operation: all four channels FULL, pulse `rst_n` low between edges → valids drop immediately with no clock edge. With `DEMUX_1X4_STATS_EN`, counters read 0.
